// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the bus-based CPU datapath.
// It runs the fetch T-states, decodes IR[31:27] and then steps the execute T-states.
module control_sequencer #(
    parameter int                OP_W    = 5,
    parameter logic [OP_W-1:0]   ALU_ADD = 5'b00011
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     ir,
    input  logic            con_ff,
    output logic            PCout,
    output logic            IncPC,
    output logic            ZLOout,
    output logic            ZLOin,
    output logic            ZHIout,
    output logic            Cout,
    output logic            MDRout,
    output logic            RAMenable,
    output logic            MARin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            R15in,
    output logic            read,
    output logic            write,
    output logic            conin,
    output logic [OP_W-1:0] aluControl,
    output logic            run,
    output logic [3:0]      state_dbg
);

    typedef enum logic [3:0] {
        S_INIT = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

    state_t state_q, state_d;
    logic [OP_W-1:0] opcode;
    logic isAlu, isAddi, isLdi, isLd, isSt, isMem, isJr, isJal, isBr, isHalt;
    logic unusedIrBits;

    assign opcode       = ir[31:32-OP_W];
    assign unusedIrBits = ^ir[31-OP_W:0];
    assign isAlu  = (opcode >= OP_ADD) && (opcode <= OP_OR);
    assign isAddi = (opcode == OP_ADDI);
    assign isLdi  = (opcode == OP_LDI);
    assign isLd   = (opcode == OP_LD);
    assign isSt   = (opcode == OP_ST);
    assign isMem  = isLd || isSt;
    assign isJr   = (opcode == OP_JR);
    assign isJal  = (opcode == OP_JAL);
    assign isBr   = (opcode == OP_BR);
    assign isHalt = (opcode == OP_HALT);
    assign state_dbg = state_q;

    always_ff @(posedge clock) begin
        if (clear) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    // Undefined opcodes fall through to T0 from T3, exactly like nop.
    always_comb begin
        state_d    = state_q;
        PCout      = 1'b0;
        IncPC      = 1'b0;
        ZLOout     = 1'b0;
        ZLOin      = 1'b0;
        ZHIout     = 1'b0;
        Cout       = 1'b0;
        MDRout     = 1'b0;
        RAMenable  = 1'b0;
        MARin      = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        BAout      = 1'b0;
        R15in      = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        conin      = 1'b0;
        aluControl = '0;
        run        = 1'b1;
        case (state_q)
            S_INIT: state_d = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                ZLOout = 1'b1; PCin = 1'b1; read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                state_d = S_T4;
                if (isAlu || isAddi) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (isLdi || isMem) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (isJr) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                    state_d = S_T0;
                end else if (isJal) begin
                    PCout = 1'b1; R15in = 1'b1;
                end else if (isBr) begin
                    Gra = 1'b1; Rout = 1'b1; conin = 1'b1;
                end else if (isHalt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T4: begin
                state_d = S_T5;
                if (isAlu) begin
                    Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; aluControl = opcode;
                end else if (isAddi || isLdi || isMem) begin
                    Cout = 1'b1; ZLOin = 1'b1; aluControl = ALU_ADD;
                end else if (isJal) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                    state_d = S_T0;
                end else if (isBr) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T5: begin
                state_d = S_T0;
                if (isAlu || isAddi || isLdi) begin
                    ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (isMem) begin
                    ZLOout = 1'b1; MARin = 1'b1;
                    state_d = S_T6;
                end else if (isBr) begin
                    Cout = 1'b1; ZLOin = 1'b1; aluControl = ALU_ADD;
                    state_d = S_T6;
                end
            end
            S_T6: begin
                state_d = S_T0;
                if (isLd) begin
                    read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1;
                    state_d = S_T7;
                end else if (isSt) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    state_d = S_T7;
                end else if (isBr) begin
                    ZLOout = 1'b1; PCin = con_ff;
                end
            end
            S_T7: begin
                state_d = S_T0;
                if (isLd) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (isSt) begin
                    write = 1'b1; RAMenable = 1'b1;
                end
            end
            S_HALT: run = 1'b0;
            default: state_d = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed and random instruction streams compared
// cycle by cycle against per-instruction strobe sequences built from the instruction table.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        con_ff = 1'b0;
    logic PCout, IncPC, ZLOout, ZLOin, ZHIout, Cout, MDRout, RAMenable;
    logic MARin, PCin, MDRin, IRin, Yin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, R15in;
    logic read, write, conin, run;
    logic [4:0] aluControl;
    logic [3:0] state_dbg;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    control_sequencer dut (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff),
        .PCout(PCout), .IncPC(IncPC), .ZLOout(ZLOout), .ZLOin(ZLOin),
        .ZHIout(ZHIout), .Cout(Cout), .MDRout(MDRout), .RAMenable(RAMenable),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .R15in(R15in), .read(read), .write(write),
        .conin(conin), .aluControl(aluControl), .run(run), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    // One bit per strobe; aluControl sits in [5:1] and run in [0].
    localparam logic [28:0] PCOUT  = 29'h1 << 28;
    localparam logic [28:0] INCPC  = 29'h1 << 27;
    localparam logic [28:0] ZLOOUT = 29'h1 << 26;
    localparam logic [28:0] ZLOIN  = 29'h1 << 25;
    localparam logic [28:0] COUT   = 29'h1 << 23;
    localparam logic [28:0] MDROUT = 29'h1 << 22;
    localparam logic [28:0] RAMEN  = 29'h1 << 21;
    localparam logic [28:0] MARIN  = 29'h1 << 20;
    localparam logic [28:0] PCIN   = 29'h1 << 19;
    localparam logic [28:0] MDRIN  = 29'h1 << 18;
    localparam logic [28:0] IRIN   = 29'h1 << 17;
    localparam logic [28:0] YIN    = 29'h1 << 16;
    localparam logic [28:0] GRA    = 29'h1 << 15;
    localparam logic [28:0] GRB    = 29'h1 << 14;
    localparam logic [28:0] GRC    = 29'h1 << 13;
    localparam logic [28:0] RIN    = 29'h1 << 12;
    localparam logic [28:0] ROUT   = 29'h1 << 11;
    localparam logic [28:0] BAOUT  = 29'h1 << 10;
    localparam logic [28:0] R15IN  = 29'h1 << 9;
    localparam logic [28:0] READ   = 29'h1 << 8;
    localparam logic [28:0] WRITE  = 29'h1 << 7;
    localparam logic [28:0] CONIN  = 29'h1 << 6;
    localparam logic [28:0] RUN    = 29'h1;
    localparam logic [4:0]  ALU_ADD = 5'b00011;

    logic [28:0] expQ[$];

    function automatic logic [28:0] aluWord(input logic [4:0] code);
        return {23'b0, code, 1'b0};
    endfunction

    function automatic logic [28:0] observed();
        return {PCout, IncPC, ZLOout, ZLOin, ZHIout, Cout, MDRout, RAMenable,
                MARin, PCin, MDRin, IRin, Yin, Gra, Grb, Grc, Rin, Rout,
                BAout, R15in, read, write, conin, aluControl, run};
    endfunction

    // Expected per-cycle strobe words for one instruction, fetch included.
    task automatic buildSeq(input logic [4:0] op, input logic cff);
        expQ.delete();
        expQ.push_back(RUN | PCOUT | MARIN | INCPC | ZLOIN);
        expQ.push_back(RUN | ZLOOUT | PCIN | READ | RAMEN | MDRIN);
        expQ.push_back(RUN | MDROUT | IRIN);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                expQ.push_back(RUN | GRB | ROUT | YIN);
                expQ.push_back(RUN | GRC | ROUT | ZLOIN | aluWord(op));
                expQ.push_back(RUN | ZLOOUT | GRA | RIN);
            end
            5'b01100, 5'b00001: begin
                expQ.push_back(RUN | GRB | YIN | ((op == 5'b01100) ? ROUT : BAOUT));
                expQ.push_back(RUN | COUT | ZLOIN | aluWord(ALU_ADD));
                expQ.push_back(RUN | ZLOOUT | GRA | RIN);
            end
            5'b00000, 5'b00010: begin
                expQ.push_back(RUN | GRB | BAOUT | YIN);
                expQ.push_back(RUN | COUT | ZLOIN | aluWord(ALU_ADD));
                expQ.push_back(RUN | ZLOOUT | MARIN);
                if (op == 5'b00000) begin
                    expQ.push_back(RUN | READ | RAMEN | MDRIN);
                    expQ.push_back(RUN | MDROUT | GRA | RIN);
                end else begin
                    expQ.push_back(RUN | GRA | ROUT | MDRIN);
                    expQ.push_back(RUN | WRITE | RAMEN);
                end
            end
            5'b10011: expQ.push_back(RUN | GRA | ROUT | PCIN);
            5'b10100: begin
                expQ.push_back(RUN | PCOUT | R15IN);
                expQ.push_back(RUN | GRA | ROUT | PCIN);
            end
            5'b10010: begin
                expQ.push_back(RUN | GRA | ROUT | CONIN);
                expQ.push_back(RUN | PCOUT | YIN);
                expQ.push_back(RUN | COUT | ZLOIN | aluWord(ALU_ADD));
                expQ.push_back(RUN | ZLOOUT | (cff ? PCIN : 29'h0));
            end
            5'b11010: begin
                expQ.push_back(RUN);
                for (int k = 0; k < 20; k++) expQ.push_back(29'h0);
            end
            default: expQ.push_back(RUN);
        endcase
    endtask

    task automatic checkOutput(input logic [28:0] expected, input string tag);
        logic [28:0] obs;
        obs = observed();
        checkCount++;
        assert (obs === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expected);
        end
    endtask

    task automatic checkState(input logic [3:0] expected, input string tag);
        checkCount++;
        assert (state_dbg === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s state_dbg observed=%0d expected=%0d", tag, state_dbg, expected);
        end
    endtask

    // Called just after the edge that entered T0; ir changes only once T0 is sampled.
    task automatic applyStimulus(input logic [31:0] irv, input logic cff, input int maxSteps);
        int n;
        buildSeq(irv[31:27], cff);
        n = (maxSteps > 0 && maxSteps < expQ.size()) ? maxSteps : expQ.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            checkOutput(expQ[i], $sformatf("op%b step%0d", irv[31:27], i));
            if (i == 0) begin
                ir     = irv;
                con_ff = cff;
            end
        end
    endtask

    task automatic doClear(input int cycles);
        clear = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            checkOutput(RUN, $sformatf("init cycle%0d", i));
            checkState(4'd0, $sformatf("init cycle%0d", i));
        end
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [4:0] op;
        doClear(1);
        applyStimulus(32'h1A2B8000, 1'b0, 0);
        applyStimulus(32'h98000000, 1'b0, 0);
        applyStimulus({5'b10010, 27'h0123456}, 1'b1, 0);
        applyStimulus({5'b10010, 27'h0654321}, 1'b0, 0);
        applyStimulus({5'b00010, 27'h0ABCDEF}, 1'b0, 0);
        applyStimulus({5'b00000, 27'h0000123}, 1'b0, 0);
        applyStimulus({5'b10100, 27'h1000000}, 1'b0, 0);
        applyStimulus({5'b00000, 27'h0000040}, 1'b0, 7);
        doClear(2);
        for (int r = 0; r < 40; r++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11010) op = 5'b11001;
            applyStimulus({op, 27'($urandom)}, 1'($urandom_range(0, 1)), 0);
        end
        applyStimulus({5'b11010, 27'h0}, 1'b0, 0);
        doClear(1);
        applyStimulus({5'b00101, 27'h0222222}, 1'b0, 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit that sequences the bus-based CPU datapath.
- Runs the fetch T0–T2 sequence, decodes IR[31:27], then steps the execute T-states for the supported subset.
- Drives every datapath strobe the datapath module consumes.
- Sits beside DataPath in the CPU top. IR comes from the datapath; strobes go into it.

Parameters:
- ALU_ADD, 5'b00011, aluControl code for address/immediate add
- OP_W, 5, opcode width (IR[31:27])

Ports:
- clock  in  1  system clock; all state changes on rising edge
- clear  in  1  synchronous, active-high reset
- ir  in  32  instruction register contents from datapath
- con_ff  in  1  branch-condition flip-flop output from datapath
- PCout, IncPC, ZLOout, ZLOin, ZHIout, Cout, MDRout, RAMenable  out  1 each  datapath strobes
- MARin, PCin, MDRin, IRin, Yin  out  1 each  register load strobes
- Gra, Grb, Grc, Rin, Rout, BAout, R15in  out  1 each  register-select and register-file strobes
- read, write, conin  out  1 each  memory and condition strobes
- aluControl  out  5  ALU operation select
- run  out  1  1 while executing, 0 in HALT
- state_dbg  out  4  current T-state, for bench visibility

Behaviour:
- Reset:
  - clock rising edge with clear=1 → state INIT (code 0).
  - In INIT all outputs are 0, except run=1 and state_dbg=0.
  - INIT → T0 on the next edge when clear=0.
  - clear mid-instruction aborts the instruction; no further strobes are issued after that edge.
- Timing:
  - Outputs are a pure decode of the state register (Moore); each T-state lasts exactly one clock.
  - Any strobe not listed for a state is 0; aluControl=0 unless listed.
- Fetch (all instructions):
  - T0: PCout, MARin, IncPC, ZLOin.
  - T1: ZLOout, PCin, read, RAMenable, MDRin.
  - T2: MDRout, IRin.
  - T2 → T3.
  - The opcode is decoded from ir in T3 onward; ir is stable after T2.
- add 00011 / sub 00100 / and 00101 / or 00110:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ZLOin, aluControl=opcode.
  - T5: ZLOout, Gra, Rin.
  - → T0.
- addi 01100:
  - T3: Grb, Rout, Yin.
  - T4: Cout, ZLOin, aluControl=ALU_ADD.
  - T5: ZLOout, Gra, Rin.
  - → T0.
- ldi 00001:
  - Same as addi, except T3 uses BAout instead of Rout (R0 reads as 0).
- ld 00000:
  - T3–T4 as ldi.
  - T5: ZLOout, MARin.
  - T6: read, RAMenable, MDRin.
  - T7: MDRout, Gra, Rin.
  - → T0.
- st 00010:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRin.
  - T7: write, RAMenable.
  - → T0.
- jr 10011:
  - T3: Gra, Rout, PCin.
  - → T0.
- jal 10100:
  - T3: PCout, R15in.
  - T4: Gra, Rout, PCin.
  - → T0.
- br 10010:
  - T3: Gra, Rout, conin.
  - T4: PCout, Yin.
  - T5: Cout, ZLOin, aluControl=ALU_ADD.
  - T6: ZLOout; PCin = con_ff, sampled during T6.
  - → T0.
- nop 11001, and any undefined opcode:
  - T3 with no strobes.
  - → T0.
- halt 11010:
  - T3 → HALT.
  - HALT: all strobes 0, run=0; HALT is held until clear.
- Invariants:
  - write and read are never asserted together.
  - PCin and PCout are never asserted together.
  - Exactly one of Gra/Grb/Grc when Rin, Rout or BAout is asserted.
- Instruction lengths in cycles, including fetch:
  - add/sub/and/or/addi/ldi: 6
  - ld, st: 8
  - jr: 4
  - jal: 5
  - br: 7
  - nop: 4

Test Plan:
- Reset: clear=1 for 2 cycles during a ld T6 → outputs all 0, run=1, state_dbg=0; after release, T0 asserts PCout/MARin/IncPC/ZLOin on the second edge.
- add, ir=0x1A2B8000 (op 00011): T3 Grb+Rout+Yin; T4 Grc+Rout+ZLOin with aluControl=00011; T5 ZLOout+Gra+Rin; T0 again 6 cycles after the previous T0.
- jr, ir=0x98000000 (op 10011): T3 is exactly Gra+Rout+PCin; next fetch T0 follows 4 cycles after the previous T0.
- br, op 10010: con_ff=1 → PCin=1 in T6; repeat with con_ff=0 → PCin=0 in T6, ZLOout still 1, next T0 follows.
- st, op 00010: T6 Gra+Rout+MDRin, T7 write+RAMenable with read=0; ld T6 read+RAMenable+MDRin with write=0.
- halt, op 11010 → run falls after T3 and stays 0 for 20 cycles with all strobes 0; clear=1 → INIT then T0.
